// File: rtl/fir_coeff_pkg.sv
// ----------------------------------------------------------------------------
// fir_coeff_pkg
//   Shared constants and types for the FIR coefficient loader and its RAM.
//
//   DEPTH : number of 64-bit coefficient words held in the RAM
//   AW    : word address width, log2(DEPTH)
//   LANES : 8-bit coefficient lanes packed into one word
//   BW    : coefficient byte width
//   WW    : coefficient word width (LANES * BW)
//   fir_state_e : loader FSM state encoding
// ----------------------------------------------------------------------------
package fir_coeff_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int LANES = 8;
    localparam int BW    = 8;
    localparam int WW    = LANES * BW;

    // ST_CLEAR is only entered when the RAM-clear-after-reset build option
    // is enabled; in the default build it is never reached.
    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_ANNOUNCE = 2'd2,
        ST_CLEAR    = 2'd3
    } fir_state_e;

endpackage

// File: rtl/fir_coeff_ram.sv
// ----------------------------------------------------------------------------
// fir_coeff_ram
//   1R1W DEPTH x WW synchronous RAM with a registered read port.
//   A read and a write to the same address in the same cycle return the
//   old word (read-before-write). Array contents are not reset; only the
//   read data register is.
//
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset (read register only)
//     we_i      : write enable
//     waddr_i   : write address
//     wdata_i   : write data
//     re_i      : read enable; rdata_o updates on the next edge, else holds
//     raddr_i   : read address
//     rdata_o   : registered read data
// ----------------------------------------------------------------------------
module fir_coeff_ram
    import fir_coeff_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [WW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [WW-1:0] rdata_o
);

    logic [WW-1:0] mem_q [DEPTH];
    logic [WW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking update of mem_q means a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// ----------------------------------------------------------------------------
// fir_coeff_loader
//   Packs an 8-bit coefficient byte stream into 64-bit words (little-endian
//   lanes), stores them in a DEPTH-entry RAM read by the fir stage, and
//   announces the base address of each completed coefficient set.
//
//   Build option FIR_COEFF_LOADER_CLEAR_EN: when defined, the loader zeroes
//   every RAM word (one per cycle) after reset before accepting bytes.
//
//   Handshakes: a transfer happens on a rising edge where both vld and rdy
//   are high. The producer holds dat/vld (and last) stable until accepted;
//   rdy never depends combinationally on vld.
//
//   Ports:
//     clk, rst            : clock and synchronous active-high reset
//     cfg_rsc_dat/vld/last: coefficient byte input stream, last ends a set
//     cfg_rsc_rdy         : loader accepts a byte (FILL only)
//     coeffs_rsc_radr/re  : fir read request, latency one
//     coeffs_rsc_q        : registered read data
//     coeff_addr_rsc_*    : base address of the completed set, vld/rdy
//     wptr_o              : next RAM write address
//     state_o             : current FSM state (debug)
// ----------------------------------------------------------------------------
module fir_coeff_loader
    import fir_coeff_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] cfg_rsc_dat,
    input  logic          cfg_rsc_vld,
    input  logic          cfg_rsc_last,
    output logic          cfg_rsc_rdy,
    input  logic [AW-1:0] coeffs_rsc_radr,
    input  logic          coeffs_rsc_re,
    output logic [WW-1:0] coeffs_rsc_q,
    output logic [AW-1:0] coeff_addr_rsc_dat,
    output logic          coeff_addr_rsc_vld,
    input  logic          coeff_addr_rsc_rdy,
    output logic [AW-1:0] wptr_o,
    output fir_state_e    state_o
);

    fir_state_e    state_q;
    logic          rdy_q;
    logic [2:0]    lane_q;
    logic [WW-1:0] asm_q;
    logic          last_q;     // the word being committed closes a set
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] wptr_d;
    logic [AW-1:0] base_q;     // first word address of the set being loaded
    logic          avld_q;
    logic [AW-1:0] adat_q;
`ifdef FIR_COEFF_LOADER_CLEAR_EN
    logic [AW-1:0] clr_q;
`endif

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [WW-1:0] ram_wdata;

    // AW-bit arithmetic wraps DEPTH-1 -> 0 on its own.
    assign wptr_d = wptr_q + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef FIR_COEFF_LOADER_CLEAR_EN
            state_q <= ST_CLEAR;
            rdy_q   <= 1'b0;
            clr_q   <= '0;
`else
            state_q <= ST_FILL;
            rdy_q   <= 1'b1;
`endif
            lane_q  <= '0;
            asm_q   <= '0;
            last_q  <= 1'b0;
            wptr_q  <= '0;
            base_q  <= '0;
            avld_q  <= 1'b0;
            adat_q  <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (cfg_rsc_vld && rdy_q) begin
                        asm_q[{lane_q, 3'b000} +: BW] <= cfg_rsc_dat;
                        lane_q <= lane_q + 3'd1;
                        if (lane_q == 3'(LANES - 1) || cfg_rsc_last) begin
                            state_q <= ST_COMMIT;
                            rdy_q   <= 1'b0;
                            last_q  <= cfg_rsc_last;
                        end
                    end
                end

                // The RAM write of asm_q happens this cycle (see write mux).
                ST_COMMIT: begin
                    wptr_q <= wptr_d;
                    lane_q <= '0;
                    asm_q  <= '0;
                    if (last_q) begin
                        state_q <= ST_ANNOUNCE;
                        avld_q  <= 1'b1;
                        adat_q  <= base_q;
                    end else begin
                        state_q <= ST_FILL;
                        rdy_q   <= 1'b1;
                    end
                end

                ST_ANNOUNCE: begin
                    if (avld_q && coeff_addr_rsc_rdy) begin
                        avld_q  <= 1'b0;
                        base_q  <= wptr_q;
                        state_q <= ST_FILL;
                        rdy_q   <= 1'b1;
                    end
                end

`ifdef FIR_COEFF_LOADER_CLEAR_EN
                ST_CLEAR: begin
                    clr_q <= clr_q + AW'(1);
                    if (clr_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_FILL;
                        rdy_q   <= 1'b1;
                    end
                end
`endif

                default: begin
                    state_q <= ST_FILL;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    // RAM write port: committed words, or zeros while clearing.
    always_comb begin
        ram_we    = (state_q == ST_COMMIT);
        ram_waddr = wptr_q;
        ram_wdata = asm_q;
`ifdef FIR_COEFF_LOADER_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_q;
            ram_wdata = '0;
        end
`endif
    end

    fir_coeff_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (coeffs_rsc_re),
        .raddr_i (coeffs_rsc_radr),
        .rdata_o (coeffs_rsc_q)
    );

    assign cfg_rsc_rdy        = rdy_q;
    assign coeff_addr_rsc_vld = avld_q;
    assign coeff_addr_rsc_dat = adat_q;
    assign wptr_o             = wptr_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// ----------------------------------------------------------------------------
// tb_fir_coeff_loader
//   Self-checking bench for fir_coeff_loader. A reference model keeps the
//   expected RAM image, write pointer and set base; announced base
//   addresses are queued in exp_q and popped when the DUT presents them.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_fir_coeff_loader;
  import fir_coeff_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    cfg_dat;
  logic          cfg_vld;
  logic          cfg_last;
  logic          cfg_rdy;
  logic [AW-1:0] radr;
  logic          re;
  logic [63:0]   q;
  logic [AW-1:0] adat;
  logic          avld;
  logic          ardy;
  logic [AW-1:0] wptr;
  fir_state_e    state;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [63:0]   mem_m [DEPTH];
  logic [AW-1:0] wptr_m;
  logic [AW-1:0] base_m;
  logic [AW-1:0] exp_q [$];
  logic [7:0]    byte_q [$];

  fir_coeff_loader dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_rsc_dat        (cfg_dat),
    .cfg_rsc_vld        (cfg_vld),
    .cfg_rsc_last       (cfg_last),
    .cfg_rsc_rdy        (cfg_rdy),
    .coeffs_rsc_radr    (radr),
    .coeffs_rsc_re      (re),
    .coeffs_rsc_q       (q),
    .coeff_addr_rsc_dat (adat),
    .coeff_addr_rsc_vld (avld),
    .coeff_addr_rsc_rdy (ardy),
    .wptr_o             (wptr),
    .state_o            (state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- drivers
`ifdef FIR_COEFF_LOADER_CLEAR_EN
  // Called on the first falling edge after the last reset edge.
  task automatic wait_clear();
    int n;
    n = 0;
    while (cfg_rdy !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL clear_len rdy low cycles got %0d exp 32", n);
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask
`endif

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cfg_vld = 1'b0; cfg_last = 1'b0; re = 1'b0; ardy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wptr_m = '0;
    base_m = '0;
    exp_q.delete();
`ifdef FIR_COEFF_LOADER_CLEAR_EN
    wait_clear();
`endif
  endtask

  // Idle gap cycles carry random last with vld low, which must be ignored.
  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      cfg_vld = 1'b0; cfg_last = 1'($urandom_range(0, 1)); cfg_dat = 8'($urandom);
      @(negedge clk);
    end
    cfg_vld = 1'b1; cfg_dat = d; cfg_last = l;
    n = 0;
    while (cfg_rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout rdy got %b exp 1", cfg_rdy);
    end
    @(negedge clk);
    cfg_vld = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic check_read(input logic [AW-1:0] a, input logic [63:0] e);
    @(negedge clk);
    re = 1'b1; radr = a;
    @(negedge clk);
    re = 1'b0;
    checks++;
    if (q !== e) begin
      errors++;
      $display("FAIL read addr %0d got %h exp %h", a, q, e);
    end
    radr = ~a;
    @(negedge clk);
    checks++;
    if (q !== e) begin
      errors++;
      $display("FAIL read_hold addr %0d got %h exp %h", a, q, e);
    end
  endtask

  // Waits for the announcement, holds rdy low for 'hold' cycles while
  // offering bytes that must not be taken, then accepts it.
  task automatic take_announce(input int hold);
    int n;
    logic [AW-1:0] e;
    n = 0;
    while (avld !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (avld !== 1'b1) begin
      errors++;
      $display("FAIL announce_timeout vld got %b exp 1", avld);
    end
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if (adat !== e || wptr !== wptr_m) begin
      errors++;
      $display("FAIL announce dat got %0d exp %0d wptr got %0d exp %0d", adat, e, wptr, wptr_m);
    end
    for (int h = 0; h < hold; h++) begin
      cfg_vld = 1'b1; cfg_dat = 8'($urandom); cfg_last = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (avld !== 1'b1 || adat !== e || cfg_rdy !== 1'b0 || wptr !== wptr_m) begin
        errors++;
        $display("FAIL backpressure vld %b dat %0d rdy %b wptr %0d exp 1 %0d 0 %0d",
                 avld, adat, cfg_rdy, wptr, e, wptr_m);
      end
    end
    cfg_vld = 1'b0; cfg_last = 1'b0;
    ardy = 1'b1;
    @(negedge clk);
    ardy = 1'b0;
    base_m = wptr_m;
    checks++;
    if (avld !== 1'b0 || cfg_rdy !== 1'b1 || state !== ST_FILL) begin
      errors++;
      $display("FAIL announce_done vld %b rdy %b state %0d exp 0 1 %0d", avld, cfg_rdy, state, ST_FILL);
    end
  endtask

  // Sends byte_q as one set (or as plain words if with_last is 0) and
  // updates the model: 8 bytes per word, little-endian, short tail zero-padded.
  task automatic load_set(input bit with_last, input int hold, input int maxgap);
    int nb;
    int nw;
    logic [63:0] w;
    nb = byte_q.size();
    nw = (nb + 7) / 8;
    if (with_last) exp_q.push_back(base_m);
    for (int j = 0; j < nw; j++) begin
      w = '0;
      for (int k = 0; k < 8; k++)
        if (8 * j + k < nb) w[8*k +: 8] = byte_q[8*j + k];
      mem_m[wptr_m] = w;
      wptr_m = wptr_m + AW'(1);
    end
    for (int i = 0; i < nb; i++)
      send_byte(byte_q[i], with_last && (i == nb - 1), $urandom_range(0, maxgap));
    if (with_last) take_announce(hold);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    do_reset();
    checks++;
    if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", cfg_rdy); end
    checks++;
    if (q !== 64'h0) begin errors++; $display("FAIL reset_q got %h exp 0", q); end
    checks++;
    if (avld !== 1'b0 || adat !== '0) begin
      errors++; $display("FAIL reset_addr vld %b dat %0d exp 0 0", avld, adat);
    end
    checks++;
    if (wptr !== '0) begin errors++; $display("FAIL reset_wptr got %0d exp 0", wptr); end
    checks++;
    if (state !== ST_FILL) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, ST_FILL); end
  endtask

  task automatic test_basic();
    byte_q.delete();
    for (int i = 1; i <= 8; i++) byte_q.push_back(8'(i));
    load_set(1'b1, 3, 0);
    checks++;
    if (wptr !== AW'(1)) begin errors++; $display("FAIL basic_wptr got %0d exp 1", wptr); end
    check_read(0, 64'h0807060504030201);
    byte_q.delete();
    byte_q.push_back(8'hAA); byte_q.push_back(8'hBB); byte_q.push_back(8'hCC);
    load_set(1'b1, 0, 1);
    check_read(1, 64'h0000000000CCBBAA);
    checks++;
    if (wptr !== AW'(2)) begin errors++; $display("FAIL short_wptr got %0d exp 2", wptr); end
  endtask

  task automatic test_single_byte();
    byte_q.delete();
    byte_q.push_back(8'h5A);
    load_set(1'b1, 1, 2);
    check_read(2, 64'h000000000000005A);
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] start;
    start = wptr_m;
    byte_q.delete();
    for (int i = 0; i < 5; i++) byte_q.push_back(8'($urandom));
    load_set(1'b1, 10, 1);
    check_read(start, mem_m[start]);
  endtask

  task automatic test_wrap();
    do_reset();
    byte_q.delete();
    for (int i = 0; i < 33 * 8; i++) byte_q.push_back(8'($urandom));
    load_set(1'b1, 2, 0);
    checks++;
    if (wptr !== AW'(1)) begin errors++; $display("FAIL wrap_wptr got %0d exp 1", wptr); end
    check_read(0, mem_m[0]);
    check_read(1, mem_m[1]);
    check_read(31, mem_m[31]);
  endtask

  task automatic test_collision();
    logic [63:0]   oldw;
    logic [63:0]   neww;
    logic [7:0]    b [8];
    logic [AW-1:0] ca;
    byte_q.delete();
    for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom));
    load_set(1'b0, 0, 0);
    ca = wptr_m;
    neww = '0;
    for (int k = 0; k < 8; k++) begin
      b[k] = 8'($urandom);
      neww[8*k +: 8] = b[k];
    end
    oldw = mem_m[ca];
    exp_q.push_back(base_m);
    for (int k = 0; k < 7; k++) send_byte(b[k], 1'b0, 0);
    cfg_vld = 1'b1; cfg_dat = b[7]; cfg_last = 1'b1;
    checks++;
    if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL coll_rdy got %b exp 1", cfg_rdy); end
    @(negedge clk);
    // FSM is now in the commit cycle for address ca: read it concurrently.
    cfg_vld = 1'b0; cfg_last = 1'b0; re = 1'b1; radr = ca;
    @(negedge clk);
    re = 1'b0;
    checks++;
    if (q !== oldw) begin errors++; $display("FAIL collision_old got %h exp %h", q, oldw); end
    mem_m[ca] = neww;
    wptr_m = wptr_m + AW'(1);
    check_read(ca, neww);
    take_announce(2);
  endtask

  task automatic test_random();
    logic [AW-1:0] start;
    int nb;
    for (int s = 0; s < 6; s++) begin
      start = wptr_m;
      nb = $urandom_range(1, 20);
      byte_q.delete();
      for (int i = 0; i < nb; i++) byte_q.push_back(8'($urandom));
      load_set(1'b1, $urandom_range(0, 3), 2);
      for (int j = 0; j < (nb + 7) / 8; j++) check_read(start + AW'(j), mem_m[start + AW'(j)]);
    end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 0);
    cfg_vld = 1'b1; cfg_dat = 8'($urandom); cfg_last = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cfg_vld = 1'b0;
    exp_q.delete();
    wptr_m = '0;
    base_m = '0;
    checks++;
    if (wptr !== '0 || avld !== 1'b0) begin
      errors++; $display("FAIL midrst wptr %0d vld %b exp 0 0", wptr, avld);
    end
`ifdef FIR_COEFF_LOADER_CLEAR_EN
    wait_clear();
`else
    checks++;
    if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy got %b exp 1", cfg_rdy); end
`endif
    for (int a = 0; a < DEPTH; a++) check_read(AW'(a), mem_m[a]);
    byte_q.delete();
    byte_q.push_back(8'h11); byte_q.push_back(8'h22);
    load_set(1'b1, 0, 0);
    check_read(0, 64'h0000000000002211);
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    rst = 1'b1; cfg_dat = '0; cfg_vld = 1'b0; cfg_last = 1'b0;
    radr = '0; re = 1'b0; ardy = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;
    test_reset();
    test_basic();
    test_single_byte();
    test_backpressure();
    test_wrap();
    test_collision();
    test_random();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
